// File: rtl/e2prom_bist_ctrl.sv
// EEPROM self-test sequencer: writes a pattern over an address window through an I2C master, then reads it back and counts mismatches.
// i2c_exec/addr/data are registered (exec appears the cycle after a request state); each NACK is retried up to MAX_RETRY times per byte.
module e2prom_bist_ctrl #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          NUM_BYTES   = 256,
    parameter int          WR_WAIT_CYC = 12000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [1:0]  pat_sel,
    input  logic [7:0]  seed,
    input  logic        stop_on_err,
    output logic        i2c_rh_wl,
    output logic        i2c_exec,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        busy,
    output logic        rw_done,
    output logic        rw_res,
    output logic [15:0] err_cnt,
    output logic [15:0] err_addr
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, WR_WAIT, RD_REQ, RD_RESP, FIN} state_t;

    localparam logic [16:0] LAST_IDX  = 17'(NUM_BYTES - 1);
    localparam logic [31:0] WAIT_LAST = (WR_WAIT_CYC > 0) ? 32'(WR_WAIT_CYC - 1) : 32'd0;
    localparam logic [15:0] RETRY_MAX = 16'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [16:0] index_q, index_d;
    logic [15:0] retry_q, retry_d;
    logic [31:0] wait_q, wait_d;
    logic [1:0]  mode_q, mode_d, pat_q, pat_d;
    logic [7:0]  seed_q, seed_d;
    logic        stop_q, stop_d, nack_q, nack_d;
    logic [15:0] err_cnt_q, err_cnt_d, err_addr_q, err_addr_d;
    logic        busy_q, busy_d, done_q, done_d, res_q, res_d;
    logic        exec_q, exec_d, rh_q, rh_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d;

    logic [15:0] cur_addr;
    logic [7:0]  cur_pat;
    logic        is_last, retry_left;

    always_comb begin
        cur_addr = BASE_ADDR + index_q[15:0];
        case (pat_q)
            2'd0:    cur_pat = seed_q + index_q[7:0];
            2'd1:    cur_pat = cur_addr[7:0] ^ seed_q;
            2'd2:    cur_pat = seed_q;
            default: cur_pat = ~cur_addr[7:0];
        endcase
        is_last    = (index_q == LAST_IDX);
        retry_left = (retry_q < RETRY_MAX);
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        retry_d    = retry_q;
        wait_d     = wait_q;
        mode_d     = mode_q;
        pat_d      = pat_q;
        seed_d     = seed_q;
        stop_d     = stop_q;
        nack_d     = nack_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        busy_d     = busy_q;
        res_d      = res_q;
        rh_d       = rh_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        exec_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    pat_d      = pat_sel;
                    seed_d     = seed;
                    stop_d     = stop_on_err;
                    index_d    = '0;
                    retry_d    = '0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    nack_d     = 1'b0;
                    res_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = (mode == 2'd1) ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                exec_d  = 1'b1;
                rh_d    = 1'b0;
                addr_d  = cur_addr;
                wdat_d  = cur_pat;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                if (i2c_done) begin
                    wait_d = '0;
                    if (!i2c_ack) begin
                        retry_d = '0;
                        index_d = index_q + 17'd1;
                        state_d = WR_WAIT;
                    end else if (retry_left) begin
                        retry_d = retry_q + 16'd1;
                        state_d = WR_WAIT;
                    end else begin
                        err_addr_d = cur_addr;
                        nack_d     = 1'b1;
                        state_d    = FIN;
                    end
                end
            end
            WR_WAIT: begin
                wait_d = wait_q + 32'd1;
                if (wait_q >= WAIT_LAST) begin
                    wait_d = '0;
                    // index already points past the last written byte when the window is done
                    if (index_q <= LAST_IDX) begin
                        state_d = WR_REQ;
                    end else if (mode_q == 2'd2) begin
                        state_d = FIN;
                    end else begin
                        index_d = '0;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                exec_d  = 1'b1;
                rh_d    = 1'b1;
                addr_d  = cur_addr;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (i2c_done) begin
                    if (i2c_ack) begin
                        if (retry_left) begin
                            retry_d = retry_q + 16'd1;
                            state_d = RD_REQ;
                        end else begin
                            err_addr_d = cur_addr;
                            nack_d     = 1'b1;
                            state_d    = FIN;
                        end
                    end else begin
                        retry_d = '0;
                        if (i2c_data_r != cur_pat) begin
                            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                            if (err_cnt_q == 16'd0) err_addr_d = cur_addr;
                        end
                        if (is_last || (stop_q && (i2c_data_r != cur_pat))) begin
                            state_d = FIN;
                        end else begin
                            index_d = index_q + 17'd1;
                            state_d = RD_REQ;
                        end
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                res_d   = !nack_q && (err_cnt_q == 16'd0);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            retry_q    <= '0;
            wait_q     <= '0;
            mode_q     <= '0;
            pat_q      <= '0;
            seed_q     <= '0;
            stop_q     <= 1'b0;
            nack_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= 1'b0;
            exec_q     <= 1'b0;
            rh_q       <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            retry_q    <= retry_d;
            wait_q     <= wait_d;
            mode_q     <= mode_d;
            pat_q      <= pat_d;
            seed_q     <= seed_d;
            stop_q     <= stop_d;
            nack_q     <= nack_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_q      <= res_d;
            exec_q     <= exec_d;
            rh_q       <= rh_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
        end
    end

    assign i2c_rh_wl  = rh_q;
    assign i2c_exec   = exec_q;
    assign i2c_addr   = addr_q;
    assign i2c_data_w = wdat_q;
    assign busy       = busy_q;
    assign rw_done    = done_q;
    assign rw_res     = res_q;
    assign err_cnt    = err_cnt_q;
    assign err_addr   = err_addr_q;
endmodule

// File: tb/tb_e2prom_bist_ctrl.sv
// Bench for e2prom_bist_ctrl: an I2C slave model with NACK/corruption injection, a reference model filling
// expected-transaction and expected-result queues, and a monitor that pops and compares on every exec / rw_done.
module tb_e2prom_bist_ctrl;
    localparam logic [15:0] BASE = 16'h0010;
    localparam int NB   = 4;
    localparam int WCYC = 5;
    localparam int MR   = 3;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop_on_err = 1'b0;
    logic [1:0]  mode = 2'd0, pat_sel = 2'd0;
    logic [7:0]  seed = 8'd0;
    logic        i2c_rh_wl, i2c_exec;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  i2c_data_r = 8'd0;
    logic        i2c_done = 1'b0, i2c_ack = 1'b0;
    logic        busy, rw_done, rw_res;
    logic [15:0] err_cnt, err_addr;

    e2prom_bist_ctrl #(.BASE_ADDR(BASE), .NUM_BYTES(NB), .WR_WAIT_CYC(WCYC), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pat_sel(pat_sel), .seed(seed),
        .stop_on_err(stop_on_err), .i2c_rh_wl(i2c_rh_wl), .i2c_exec(i2c_exec), .i2c_addr(i2c_addr),
        .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .busy(busy), .rw_done(rw_done), .rw_res(rw_res), .err_cnt(err_cnt), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic rw; logic [15:0] addr; logic [7:0] data; } txn_t;
    typedef struct packed { logic res; logic [15:0] cnt; logic [15:0] addr; } res_t;
    txn_t exp_txn[$];
    res_t exp_res[$];

    int checks = 0, errors = 0;
    int wr_nack[NB], rd_nack[NB], s_wr_left[NB], s_rd_left[NB];
    bit bad[NB];
    logic [7:0] mem [65536];
    bit gap_pend = 0;
    int wr_done_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] pat_fn(input logic [1:0] sel, input logic [7:0] sd, input int i);
        logic [15:0] a;
        logic [7:0]  lo;
        a  = BASE + 16'(i);
        lo = a[7:0];
        case (sel)
            2'd0:    return sd + 8'(i);
            2'd1:    return lo ^ sd;
            2'd2:    return sd;
            default: return ~lo;
        endcase
    endfunction

    // Expected behaviour derived byte by byte from the test rules, using a copy of the slave memory.
    task automatic run_model(input logic [1:0] md, input logic [1:0] ps, input logic [7:0] sd, input bit stp);
        logic [7:0]  img [NB];
        bit          abort;
        logic [15:0] cnt, ea, a;
        logic [7:0]  p, got;
        int          tries;
        abort = 0; cnt = 0; ea = 0;
        for (int i = 0; i < NB; i++) img[i] = mem[BASE + 16'(i)];
        if (md != 2'd1) begin
            for (int i = 0; i < NB && !abort; i++) begin
                a = BASE + 16'(i);
                p = pat_fn(ps, sd, i);
                tries = (wr_nack[i] > MR) ? MR + 1 : wr_nack[i] + 1;
                repeat (tries) exp_txn.push_back('{1'b0, a, p});
                if (wr_nack[i] > MR) begin abort = 1; ea = a; end
                else img[i] = p;
            end
        end
        if (!abort && md != 2'd2) begin
            for (int i = 0; i < NB && !abort; i++) begin
                a = BASE + 16'(i);
                p = pat_fn(ps, sd, i);
                tries = (rd_nack[i] > MR) ? MR + 1 : rd_nack[i] + 1;
                repeat (tries) exp_txn.push_back('{1'b1, a, 8'h00});
                if (rd_nack[i] > MR) begin abort = 1; ea = a; end
                else begin
                    got = img[i] ^ (bad[i] ? 8'h01 : 8'h00);
                    if (got != p) begin
                        if (cnt == 0) ea = a;
                        if (cnt != 16'hFFFF) cnt++;
                        if (stp) break;
                    end
                end
            end
        end
        exp_res.push_back('{(!abort && cnt == 0), cnt, ea});
    endtask

    // I2C slave: random 1..4 cycle latency, injectable NACKs and read corruption.
    initial begin : slave
        bit          pend;
        int          lat, idx;
        bit          inr;
        logic        l_rw;
        logic [15:0] l_addr;
        logic [7:0]  l_dat;
        pend = 0; lat = 0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_ack  = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (pend) begin
                if (lat > 0) lat = lat - 1;
                else begin
                    pend = 0;
                    chk("hold_addr", i2c_addr, l_addr);
                    chk("hold_rw", i2c_rh_wl, l_rw);
                    if (!l_rw) chk("hold_wdat", i2c_data_w, l_dat);
                    idx = int'(l_addr - BASE);
                    inr = (idx < NB);
                    i2c_done = 1'b1;
                    if (l_rw) begin
                        if (inr && s_rd_left[idx] > 0) begin s_rd_left[idx]--; i2c_ack = 1'b1; end
                        i2c_data_r = mem[l_addr] ^ ((inr && bad[idx]) ? 8'h01 : 8'h00);
                    end else begin
                        if (inr && s_wr_left[idx] > 0) begin s_wr_left[idx]--; i2c_ack = 1'b1; end
                        else mem[l_addr] = l_dat;
                        wr_done_cyc = cyc;
                        gap_pend    = 1;
                    end
                end
            end else if (i2c_exec) begin
                pend   = 1;
                lat    = $urandom_range(0, 3);
                l_rw   = i2c_rh_wl;
                l_addr = i2c_addr;
                l_dat  = i2c_data_w;
            end
        end
    end

    initial begin : monitor
        txn_t t;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i2c_exec) begin
                    // write-cycle idle, plus the request cycle and the registered exec
                    if (gap_pend) begin
                        chk("wr_wait_gap", cyc - wr_done_cyc, WCYC + 2);
                        gap_pend = 0;
                    end
                    if (exp_txn.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_exec: got exec rw=%b addr=%h, required no transaction", i2c_rh_wl, i2c_addr);
                    end else begin
                        t = exp_txn.pop_front();
                        chk("exec_rw", i2c_rh_wl, t.rw);
                        chk("exec_addr", i2c_addr, t.addr);
                        if (!t.rw) chk("exec_wdat", i2c_data_w, t.data);
                    end
                end
                if (rw_done) begin
                    gap_pend = 0;
                    if (exp_res.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got rw_done, required none");
                    end else begin
                        r = exp_res.pop_front();
                        chk("rw_res", rw_res, r.res);
                        chk("err_cnt", err_cnt, r.cnt);
                        chk("err_addr", err_addr, r.addr);
                        chk("busy_at_done", busy, 0);
                    end
                end
            end
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < NB; i++) begin wr_nack[i] = 0; rd_nack[i] = 0; bad[i] = 0; end
    endtask

    task automatic preload_rand();
        for (int i = 0; i < NB; i++) mem[BASE + 16'(i)] = 8'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (rw_done) seen = 1;
        end
        chk("done_seen", seen, 1);
        if (!seen) begin exp_txn.delete(); exp_res.delete(); end
    endtask

    task automatic run_test(input logic [1:0] md, input logic [1:0] ps, input logic [7:0] sd,
                            input bit stp, input bit poke);
        for (int i = 0; i < NB; i++) begin s_wr_left[i] = wr_nack[i]; s_rd_left[i] = rd_nack[i]; end
        run_model(md, ps, sd, stp);
        @(negedge clk);
        start = 1'b1; mode = md; pat_sel = ps; seed = sd; stop_on_err = stp;
        @(negedge clk);
        start = 1'b0; mode = 2'($urandom); pat_sel = 2'($urandom); seed = 8'($urandom); stop_on_err = 1'($urandom);
        chk("busy_after_start", busy, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1; mode = 2'd1; pat_sel = ~ps; seed = ~sd;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        chk("txn_queue_drained", exp_txn.size(), 0);
    endtask

    initial begin : stim
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_rh_wl", i2c_rh_wl, 0);
        chk("rst_exec", i2c_exec, 0);
        chk("rst_addr", i2c_addr, 0);
        chk("rst_wdat", i2c_data_w, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rw_done", rw_done, 0);
        chk("rst_rw_res", rw_res, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_addr", err_addr, 0);
        rst_n = 1'b1;

        clear_faults(); preload_rand();
        run_test(2'd0, 2'd0, 8'h20, 0, 0);

        clear_faults();
        for (int i = 0; i < NB; i++) mem[BASE + 16'(i)] = pat_fn(2'd1, 8'hFF, i);
        bad[2] = 1;
        run_test(2'd1, 2'd1, 8'hFF, 0, 0);
        run_test(2'd1, 2'd1, 8'hFF, 1, 0);

        clear_faults(); wr_nack[0] = 2;
        run_test(2'd0, 2'd2, 8'h5A, 0, 0);
        clear_faults(); wr_nack[0] = 4;
        run_test(2'd0, 2'd0, 8'h11, 0, 0);

        clear_faults(); rd_nack[1] = 3; rd_nack[3] = 4;
        run_test(2'd3, 2'd3, 8'h00, 0, 0);
        clear_faults();
        run_test(2'd2, 2'd1, 8'h3C, 0, 0);

        for (int n = 0; n < 12; n++) begin
            clear_faults(); preload_rand();
            for (int i = 0; i < NB; i++) begin
                wr_nack[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
                rd_nack[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
                bad[i]     = ($urandom_range(0, 3) == 0);
            end
            run_test(2'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        // Reset while a read is outstanding, then a clean rerun with a start pulse while busy.
        clear_faults(); preload_rand();
        for (int i = 0; i < NB; i++) begin s_wr_left[i] = 0; s_rd_left[i] = 0; end
        run_model(2'd0, 2'd0, 8'h40, 0);
        @(negedge clk);
        start = 1'b1; mode = 2'd0; pat_sel = 2'd0; seed = 8'h40; stop_on_err = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (i2c_exec && i2c_rh_wl) seen = 1;
        end
        chk("read_phase_reached", seen, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_exec", i2c_exec, 0);
        chk("midrst_rh_wl", i2c_rh_wl, 0);
        chk("midrst_addr", i2c_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_rw_res", rw_res, 0);
        exp_txn.delete(); exp_res.delete(); gap_pend = 0;
        repeat (2) @(negedge clk);
        chk("midrst_no_exec", i2c_exec, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", busy, 0);
        run_test(2'd0, 2'd1, 8'h77, 0, 1);

        repeat (5) @(negedge clk);
        chk("res_queue_drained", exp_res.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
